parking_gate_controller: RTL and testbench
==========================================

// Module: parking_gate_controller
// PURPOSE
//  Successor to the basic entry/exit gate FSM. Drives a single motorised barrier.
//  - Motor travel time, hold-open timeout and lot capacity are parametrised.
//  - Tracks lot occupancy and refuses entries when the lot is full.
//  - Reverses a closing gate when the obstruction sensor fires.
//  Sits between the lane sensors and the barrier motor driver.
// PARAMETERS
//  TRAVEL_CYCLES  4   cycles gate_open/gate_close are asserted per movement (>=1)
//  HOLD_CYCLES    16  max cycles in OPEN before auto-close (>=1)
//  CAPACITY       8   max vehicles in lot (1..2**CNT_W-1)
//  CNT_W          4   occupancy counter width
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset_n       in   1      asynchronous active-low reset
//  entry_sensor  in   1      vehicle at entry; level, rising edge = request
//  exit_sensor   in   1      vehicle at exit; level, rising edge = request
//  pass_sensor   in   1      vehicle cleared barrier; rising edge = close request
//  obstruction   in   1      level; high = object under barrier
//  gate_open     out  1      motor open drive
//  gate_close    out  1      motor close drive
//  gate_is_open  out  1      high while state==OPEN
//  occupancy     out  CNT_W  vehicles currently in lot
//  lot_full      out  1      occupancy==CAPACITY
//  entry_denied  out  1      1-cycle pulse, entry request refused
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low.
//  - Reset value: reset_n low -> state CLOSED, timers 0, occupancy 0, sensor delay regs 0.
//    All outputs read 0 immediately, including mid-movement.
//  - Edge detect: edge = sensor & ~sensor_d, where sensor_d is registered.
//    An edge sampled at clock k acts on that same edge; outputs change after edge k.
//  - States: CLOSED, OPENING, OPEN, CLOSING. Outputs are decoded from state only:
//    gate_open = OPENING; gate_close = CLOSING; gate_is_open = OPEN.
//  - CLOSED:
//    - exit edge -> OPENING; occupancy-1, saturating at 0.
//    - else entry edge with occupancy<CAPACITY -> OPENING; occupancy+1.
//    - entry edge with lot_full -> stay CLOSED; entry_denied pulses.
//    - simultaneous entry+exit edges: exit wins; entry is dropped with an entry_denied pulse.
//  - Entry/exit edges outside CLOSED are ignored: no count change, no denied pulse.
//  - OPENING: travel timer loads TRAVEL_CYCLES on entry to the state.
//    -> OPEN after exactly TRAVEL_CYCLES cycles.
//  - OPEN: hold timer loads HOLD_CYCLES.
//    -> CLOSING on a pass_sensor edge or when the hold timer expires
//       (exactly HOLD_CYCLES cycles in OPEN).
//  - CLOSING: TRAVEL_CYCLES cycles, then -> CLOSED.
//    obstruction high on any CLOSING cycle -> OPENING next cycle, travel timer fully reloaded.
//    Occupancy is unchanged by a reversal.
//  - obstruction is ignored in all states except CLOSING.
//  - Timer widths are $clog2(max(TRAVEL_CYCLES,HOLD_CYCLES)+1).
//  - occupancy never wraps; lot_full is combinational from occupancy.
//  - Illegal state -> CLOSED next cycle.
// CONFIGURATION
//  MANUAL_OVERRIDE_EN defined:
//    - Adds input manual_open (1 bit). While it is high:
//      - CLOSED or CLOSING -> OPENING.
//      - OPEN holds with the hold timer reloaded each cycle.
//      - pass_sensor edges are ignored.
//    - Occupancy is not changed by the override.
//    - On release, the normal hold timeout restarts from HOLD_CYCLES.
//  MANUAL_OVERRIDE_EN undefined: no manual_open port, no override logic.
// TESTING (defaults)
//  1. Entry edge at occ 0 -> gate_open high exactly 4 cycles, occ=1.
//     Then OPEN for 16 cycles, gate_close 4 cycles, then CLOSED.
//  2. Eight accepted entries -> occ=8, lot_full=1.
//     9th entry edge -> entry_denied one cycle, state CLOSED, occ stays 8.
//  3. obstruction=1 on 2nd CLOSING cycle -> gate_opening next cycle for 4 cycles, occ unchanged.
//  4. occ=8, entry+exit edges on the same cycle -> OPENING, occ=7, entry_denied one pulse.
//  5. Exit edge at occ=0 -> gate opens, occ stays 0.
//     pass_sensor edge in OPEN cycle 3 -> CLOSING next cycle.
//  6. reset_n low during OPENING cycle 2 -> gate_open=0 and occ=0 without a clock.
//     After release, the first entry edge opens normally.

Source files
------------

// File: rtl/parking_gate_if.sv
// Lane-sensor and barrier-motor signal bundle; master drives the sensors, slave is the gate controller.
// manual_open exists only when MANUAL_OVERRIDE_EN is defined.
interface parking_gate_if #(
   parameter int CNT_W = 4
);
   logic             entry_sensor;
   logic             exit_sensor;
   logic             pass_sensor;
   logic             obstruction;
`ifdef MANUAL_OVERRIDE_EN
   logic             manual_open;
`endif
   logic             gate_open;
   logic             gate_close;
   logic             gate_is_open;
   logic [CNT_W-1:0] occupancy;
   logic             lot_full;
   logic             entry_denied;

   modport master (
      output entry_sensor, exit_sensor, pass_sensor, obstruction,
`ifdef MANUAL_OVERRIDE_EN
      output manual_open,
`endif
      input  gate_open, gate_close, gate_is_open, occupancy, lot_full, entry_denied
   );

   modport slave (
      input  entry_sensor, exit_sensor, pass_sensor, obstruction,
`ifdef MANUAL_OVERRIDE_EN
      input  manual_open,
`endif
      output gate_open, gate_close, gate_is_open, occupancy, lot_full, entry_denied
   );
endinterface

// File: rtl/parking_gate_controller.sv
// Barrier FSM with occupancy count and closing reversal; sensor edges act on the sampling clock, outputs follow one edge later.
// No backpressure: motor drives decode from state; MANUAL_OVERRIDE_EN adds the manual_open hold-open input.
module parking_gate_controller #(
   parameter int TRAVEL_CYCLES = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int CAPACITY      = 8,
   parameter int CNT_W         = 4
) (
   input logic           clk,
   input logic           reset_n,
   parking_gate_if.slave gate
);
   localparam int TMAX = (TRAVEL_CYCLES > HOLD_CYCLES) ? TRAVEL_CYCLES : HOLD_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0]    TRAVEL_T = TW'(TRAVEL_CYCLES);
   localparam logic [TW-1:0]    HOLD_T   = TW'(HOLD_CYCLES);
   localparam logic [TW-1:0]    ONE_T    = TW'(1);
   localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPENING = 2'd1,
      OPEN    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [TW-1:0]    timer, timer_nxt;
   logic [CNT_W-1:0] occ, occ_nxt;
   logic             denied, denied_nxt;
   logic             entry_d, exit_d, pass_d;
   logic             entry_edge, exit_edge, pass_edge;
   logic             manual_req;

`ifdef MANUAL_OVERRIDE_EN
   assign manual_req = gate.manual_open;
`else
   assign manual_req = 1'b0;
`endif

   assign entry_edge = gate.entry_sensor & ~entry_d;
   assign exit_edge  = gate.exit_sensor  & ~exit_d;
   assign pass_edge  = gate.pass_sensor  & ~pass_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= CLOSED;
         timer   <= '0;
         occ     <= '0;
         denied  <= 1'b0;
         entry_d <= 1'b0;
         exit_d  <= 1'b0;
         pass_d  <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         occ     <= occ_nxt;
         denied  <= denied_nxt;
         entry_d <= gate.entry_sensor;
         exit_d  <= gate.exit_sensor;
         pass_d  <= gate.pass_sensor;
      end
   end

   // Timers load their full count on state entry and expire on the cycle they read 1.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      occ_nxt    = occ;
      denied_nxt = 1'b0;
      case (state)
         CLOSED: begin
            if (manual_req) begin
               state_nxt = OPENING;
               timer_nxt = TRAVEL_T;
            end else if (exit_edge) begin
               state_nxt  = OPENING;
               timer_nxt  = TRAVEL_T;
               denied_nxt = entry_edge;
               if (occ != '0) occ_nxt = occ - ONE_C;
            end else if (entry_edge) begin
               if (occ < CAP_V) begin
                  state_nxt = OPENING;
                  timer_nxt = TRAVEL_T;
                  occ_nxt   = occ + ONE_C;
               end else begin
                  denied_nxt = 1'b1;
               end
            end
         end
         OPENING: begin
            if (timer <= ONE_T) begin
               state_nxt = OPEN;
               timer_nxt = HOLD_T;
            end else begin
               timer_nxt = timer - ONE_T;
            end
         end
         OPEN: begin
            if (manual_req) begin
               timer_nxt = HOLD_T;
            end else if (pass_edge || timer <= ONE_T) begin
               state_nxt = CLOSING;
               timer_nxt = TRAVEL_T;
            end else begin
               timer_nxt = timer - ONE_T;
            end
         end
         CLOSING: begin
            if (gate.obstruction || manual_req) begin
               state_nxt = OPENING;
               timer_nxt = TRAVEL_T;
            end else if (timer <= ONE_T) begin
               state_nxt = CLOSED;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer - ONE_T;
            end
         end
         default: begin
            state_nxt = CLOSED;
            timer_nxt = '0;
         end
      endcase
   end

   assign gate.gate_open    = (state == OPENING);
   assign gate.gate_close   = (state == CLOSING);
   assign gate.gate_is_open = (state == OPEN);
   assign gate.occupancy    = occ;
   assign gate.lot_full     = (occ == CAP_V);
   assign gate.entry_denied = denied;
endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed lane scenarios then random sensor traffic,
// every cycle compared against a phase/elapsed-time model of the barrier.
module tb_parking_gate_controller;
   localparam int TRAVEL = 4;
   localparam int HOLD   = 16;
   localparam int CAP    = 8;
   localparam int CNT_W  = 4;

   localparam int M_CLOSED  = 0;
   localparam int M_OPENING = 1;
   localparam int M_OPEN    = 2;
   localparam int M_CLOSING = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   parking_gate_if #(.CNT_W(CNT_W)) gif ();

   parking_gate_controller #(
      .TRAVEL_CYCLES(TRAVEL),
      .HOLD_CYCLES  (HOLD),
      .CAPACITY     (CAP),
      .CNT_W        (CNT_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .gate   (gif)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   int m_ph, m_el, m_occ;
   bit m_den, p_en, p_ex, p_ps;
   int cnt_go, cnt_io, cnt_gc;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   task automatic m_reset();
      m_ph  = M_CLOSED;
      m_el  = 0;
      m_occ = 0;
      m_den = 0;
      p_en  = 0;
      p_ex  = 0;
      p_ps  = 0;
   endtask

   // Gate as a phase plus cycles already spent in it.
   task automatic model_step();
      bit en_e, ex_e, ps_e;
      en_e  = gif.entry_sensor && !p_en;
      ex_e  = gif.exit_sensor  && !p_ex;
      ps_e  = gif.pass_sensor  && !p_ps;
      m_den = 0;
      case (m_ph)
         M_CLOSED: begin
            if (ex_e) begin
               m_ph  = M_OPENING;
               m_el  = 0;
               m_occ = (m_occ > 0) ? m_occ - 1 : 0;
               m_den = en_e;
            end else if (en_e) begin
               if (m_occ < CAP) begin
                  m_ph  = M_OPENING;
                  m_el  = 0;
                  m_occ = m_occ + 1;
               end else begin
                  m_den = 1;
               end
            end
         end
         M_OPENING: begin
            m_el++;
            if (m_el == TRAVEL) begin m_ph = M_OPEN; m_el = 0; end
         end
         M_OPEN: begin
            m_el++;
            if (ps_e || m_el == HOLD) begin m_ph = M_CLOSING; m_el = 0; end
         end
         default: begin
            if (gif.obstruction) begin
               m_ph = M_OPENING;
               m_el = 0;
            end else begin
               m_el++;
               if (m_el == TRAVEL) begin m_ph = M_CLOSED; m_el = 0; end
            end
         end
      endcase
      p_en = gif.entry_sensor;
      p_ex = gif.exit_sensor;
      p_ps = gif.pass_sensor;
   endtask

   task automatic step(input bit en, input bit ex, input bit ps, input bit ob);
      gif.entry_sensor = en;
      gif.exit_sensor  = ex;
      gif.pass_sensor  = ps;
      gif.obstruction  = ob;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (gif.gate_open)    cnt_go++;
      if (gif.gate_is_open) cnt_io++;
      if (gif.gate_close)   cnt_gc++;
      chk("gate_open",    gif.gate_open,    m_ph == M_OPENING);
      chk("gate_close",   gif.gate_close,   m_ph == M_CLOSING);
      chk("gate_is_open", gif.gate_is_open, m_ph == M_OPEN);
      chk("occupancy",    gif.occupancy,    m_occ);
      chk("lot_full",     gif.lot_full,     m_occ == CAP);
      chk("entry_denied", gif.entry_denied, m_den);
   endtask

   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      while (m_ph != ph && n < 100) begin
         step(0, 0, 0, 0);
         n++;
      end
      if (m_ph != ph) chk("phase_timeout", m_ph, ph);
   endtask

   initial begin
      gif.entry_sensor = 0;
      gif.exit_sensor  = 0;
      gif.pass_sensor  = 0;
      gif.obstruction  = 0;
`ifdef MANUAL_OVERRIDE_EN
      gif.manual_open  = 0;
`endif
      m_reset();
      #12;
      chk("rst_gate_open",    gif.gate_open, 0);
      chk("rst_gate_close",   gif.gate_close, 0);
      chk("rst_gate_is_open", gif.gate_is_open, 0);
      chk("rst_occupancy",    gif.occupancy, 0);
      chk("rst_lot_full",     gif.lot_full, 0);
      chk("rst_entry_denied", gif.entry_denied, 0);
      @(negedge clk);
      reset_n = 1;

      // Full open/hold/close cycle from a single entry.
      cnt_go = 0; cnt_io = 0; cnt_gc = 0;
      step(1, 0, 0, 0);
      for (int i = 0; i < 29; i++) step(0, 0, 0, 0);
      chk("s1_open_cycles",  cnt_go, TRAVEL);
      chk("s1_hold_cycles",  cnt_io, HOLD);
      chk("s1_close_cycles", cnt_gc, TRAVEL);
      chk("s1_occ",          gif.occupancy, 1);

      // Fill the lot, then a refused entry.
      for (int i = 0; i < CAP - 1; i++) begin
         step(1, 0, 0, 0);
         wait_phase(M_CLOSED);
      end
      chk("s2_occ_full", gif.occupancy, CAP);
      chk("s2_lot_full", gif.lot_full, 1);
      step(1, 0, 0, 0);
      chk("s2_denied",    gif.entry_denied, 1);
      chk("s2_stay_shut", gif.gate_open, 0);
      chk("s2_occ_kept",  gif.occupancy, CAP);
      step(0, 0, 0, 0);
      chk("s2_denied_pulse", gif.entry_denied, 0);

      // Simultaneous entry and exit at full, then a reversal on closing cycle 2.
      step(1, 1, 0, 0);
      chk("s4_opening", gif.gate_open, 1);
      chk("s4_occ",     gif.occupancy, CAP - 1);
      chk("s4_denied",  gif.entry_denied, 1);
      wait_phase(M_CLOSING);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("s3_reopen",     gif.gate_open, 1);
      chk("s3_occ_steady", gif.occupancy, CAP - 1);
      wait_phase(M_CLOSED);

      // Drain the lot with exits, closing early on pass edges.
      for (int i = 0; i < CAP - 1; i++) begin
         step(0, 1, 0, 0);
         wait_phase(M_OPEN);
         step(0, 0, 1, 0);
         wait_phase(M_CLOSED);
      end
      step(0, 1, 0, 0);
      chk("s5_open_on_exit", gif.gate_open, 1);
      chk("s5_occ_zero",     gif.occupancy, 0);
      wait_phase(M_OPEN);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("s5_pass_close", gif.gate_close, 1);
      wait_phase(M_CLOSED);

      // Asynchronous reset in the middle of OPENING.
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      reset_n = 0;
      #1;
      chk("s6_async_open", gif.gate_open, 0);
      chk("s6_async_occ",  gif.occupancy, 0);
      m_reset();
      @(negedge clk);
      reset_n = 1;
      step(1, 0, 0, 0);
      chk("s6_reopen", gif.gate_open, 1);
      chk("s6_occ",    gif.occupancy, 1);

      // Random lane traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
